// File: rtl/div_uint8_pkg.sv
// Shared constants and state type for the sequential unsigned divider.
// Optional remainder output is enabled with DIV_REMAINDER_EN.
package div_uint8_pkg;

    localparam int WIDTH = 8;
    localparam int ITERS = WIDTH;
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

endpackage

// File: rtl/div_uint8_step.sv
// One restoring-division iteration: shift in a dividend bit, try subtract.
module div_uint8_step
    import div_uint8_pkg::*;
(
    input  logic [WIDTH-1:0] rem_i,
    input  logic             msb_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] r;
    logic [WIDTH:0] diff;

    always_comb begin
        r     = {rem_i, msb_i};
        diff  = r - {1'b0, divisor_i};
        q_o   = (r >= {1'b0, divisor_i});
        rem_o = q_o ? diff[WIDTH-1:0] : r[WIDTH-1:0];
    end

endmodule

// File: rtl/div_uint8_seq.sv
// Sequential restoring divider, one quotient bit per clock, ready/valid on both sides.
// Define DIV_REMAINDER_EN to expose the O_rem output register and port.
module div_uint8_seq
    import div_uint8_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             I_valid,
    output logic             I_ready,
    output logic [WIDTH-1:0] O,
`ifdef DIV_REMAINDER_EN
    output logic [WIDTH-1:0] O_rem,
`endif
    output logic             O_valid,
    input  logic             O_ready
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic             o_valid_q, o_valid_d;
    logic             i_ready_q, i_ready_d;
`ifdef DIV_REMAINDER_EN
    logic [WIDTH-1:0] o_rem_q, o_rem_d;
`endif

    logic [WIDTH-1:0] rem_nx;
    logic             q_bit;

    div_uint8_step u_step (
        .rem_i     (rem_q),
        .msb_i     (dvd_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .rem_o     (rem_nx),
        .q_o       (q_bit)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        o_d       = o_q;
        o_valid_d = o_valid_q;
        i_ready_d = i_ready_q;
`ifdef DIV_REMAINDER_EN
        o_rem_d   = o_rem_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (I_valid) begin
                    state_d   = BUSY;
                    dvd_d     = I0;
                    dvs_d     = I1;
                    rem_d     = '0;
                    cnt_d     = '0;
                    i_ready_d = 1'b0;
                end
            end
            BUSY: begin
                // quotient bits accumulate in the vacated dividend LSBs
                dvd_d = {dvd_q[WIDTH-2:0], q_bit};
                rem_d = rem_nx;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d   = DONE;
                    o_d       = {dvd_q[WIDTH-2:0], q_bit};
                    o_valid_d = 1'b1;
`ifdef DIV_REMAINDER_EN
                    o_rem_d   = rem_nx;
`endif
                end
            end
            DONE: begin
                if (O_ready) begin
                    state_d   = IDLE;
                    o_valid_d = 1'b0;
                    i_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            o_q       <= '0;
            o_valid_q <= 1'b0;
            i_ready_q <= 1'b1;
`ifdef DIV_REMAINDER_EN
            o_rem_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            o_q       <= o_d;
            o_valid_q <= o_valid_d;
            i_ready_q <= i_ready_d;
`ifdef DIV_REMAINDER_EN
            o_rem_q   <= o_rem_d;
`endif
        end
    end

    assign O       = o_q;
    assign O_valid = o_valid_q;
    assign I_ready = i_ready_q;
`ifdef DIV_REMAINDER_EN
    assign O_rem   = o_rem_q;
`endif

endmodule
